// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the multi-cycle memory port and the controller that
// drives it: FSM state encoding, operation encoding, default geometry/timing,
// and a helper that decides whether a live request still matches the latched
// operation.
// -----------------------------------------------------------------------------
package mem_if_pkg;

  // Default geometry and timing, shared with the controller bench.
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 3;

  // Wait-state counter width; covers the legal WAIT_CYCLES range 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Operation selected at acceptance: a write wins when both strobes are high.
  function automatic op_t decode_op(input logic mem_read, input logic mem_write);
    return mem_write ? OP_WRITE : OP_READ;
  endfunction

  // True when the live strobes no longer describe the latched operation:
  // the request was dropped, or it swapped between read and write.
  function automatic logic req_mismatch(input op_t  op,
                                        input logic mem_read,
                                        input logic mem_write);
    if (op == OP_WRITE) return !mem_write;
    else                return !mem_read || mem_write;
  endfunction

endpackage : mem_if_pkg

// File: rtl/mem_array_sync.sv
// -----------------------------------------------------------------------------
// mem_array_sync
// 2**ADDR_W x DATA_W single-port storage with a synchronous write and a
// synchronous, registered read. The read register holds its value until the
// next read strobe, so writes and idle cycles leave it untouched.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears the read register only)
//   we     in   write enable: wdata is stored at addr on the edge
//   re     in   read enable: mem[addr] is loaded into rdata on the edge
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module mem_array_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset on purpose; resetting every word
  // would prevent mapping onto RAM and contents are defined by writes only.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule : mem_array_sync

// File: rtl/mem_ready_unit.sv
// -----------------------------------------------------------------------------
// mem_ready_unit
// Multi-cycle memory port sitting directly below the multicycle CPU
// controller. A MemRead/MemWrite request seen in IDLE is accepted: address,
// write data and operation are latched, and after WAIT_CYCLES wait states the
// access is performed on the edge that enters DONE. DONE lasts exactly one
// cycle, during which `ready` is high and (for reads) `rdata` is valid.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset; aborts any access in flight
//   MemRead   in   read request, level-held until ready
//   MemWrite  in   write request, level-held until ready
//   addr      in   word address (MAR)
//   wdata     in   write data (MDR)
//   rdata     out  registered read data toward the MDR
//   ready     out  one-cycle completion pulse
//   busy      out  high while an access is in flight (BUSY or DONE)
//   err       out  sticky protocol-error flag, cleared only by reset
//
// Build option:
//   MEM_REQ_CHECK_EN  when defined, err is also set if the live request stops
//                     matching the latched operation while in BUSY. The
//                     access still completes normally.
// -----------------------------------------------------------------------------
module mem_ready_unit
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t            state,     state_next;
  logic [CNT_W-1:0]  cnt,       cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;
  logic              err_q;

  // Per-cycle control decided by the next-state logic.
  logic              req;
  op_t               op_live;
  logic              latch_req;
  logic              do_access;
  logic              err_set;

  // Operands of the access: on a zero-wait acceptance the access happens on
  // the accepting edge itself, before the latched copies exist, so the live
  // inputs are used; otherwise only the latched copies are used.
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  op_t               acc_op;
  logic              mem_we;
  logic              mem_re;

  assign req     = MemRead | MemWrite;
  assign op_live = decode_op(MemRead, MemWrite);

  // ---------------------------------------------------------------------------
  // Next-state / control logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_req  = 1'b0;
    do_access  = 1'b0;
    err_set    = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) begin
          latch_req = 1'b1;
          cnt_next  = WAIT_CNT;
          err_set   = MemRead & MemWrite;
          if (WAIT_CNT == '0) begin
            do_access  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = BUSY;
          end
        end
      end

      BUSY: begin
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          do_access  = 1'b1;
          state_next = DONE;
        end
`ifdef MEM_REQ_CHECK_EN
        if (req_mismatch(op_q, MemRead, MemWrite)) begin
          err_set = 1'b1;
        end
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    if (state == IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_op    = op_live;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_op    = op_q;
    end
  end

  assign mem_we = do_access & (acc_op == OP_WRITE);
  assign mem_re = do_access & (acc_op == OP_READ);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch_req) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        op_q    <= op_live;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  mem_array_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready = (state == DONE);
  assign busy  = (state != IDLE);
  assign err   = err_q;

endmodule : mem_ready_unit

// File: tb/tb_mem_ready_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_ready_unit
// Directed bench for mem_ready_unit. Two instances share clock and reset:
//   u_dut_a  WAIT_CYCLES=3 (write/read latency, simultaneous request, reset
//            mid-write, mid-access request drop)
//   u_dut_z  WAIT_CYCLES=0 (back-to-back reads with ready every second cycle)
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The expected err after a mid-access request drop depends on whether
// MEM_REQ_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_ready_unit;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LIMIT = 20;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          a_rd, a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          a_ready, a_busy, a_err;

  logic          z_rd, z_wr;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_wdata, z_rdata;
  logic          z_ready, z_busy, z_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_ready_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (a_rd),
    .MemWrite (a_wr),
    .addr     (a_addr),
    .wdata    (a_wdata),
    .rdata    (a_rdata),
    .ready    (a_ready),
    .busy     (a_busy),
    .err      (a_err)
  );

  mem_ready_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_z (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (z_rd),
    .MemWrite (z_wr),
    .addr     (z_addr),
    .wdata    (z_wdata),
    .rdata    (z_rdata),
    .ready    (z_ready),
    .busy     (z_busy),
    .err      (z_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request on instance A, hold it until ready (bounded), then drop
  // it and advance one cycle back into IDLE. lat = cycles from drive to ready.
  task automatic access_a(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
    a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!a_ready && lat < LIMIT);
    a_rd = 1'b0; a_wr = 1'b0;
    step();
  endtask

  task automatic access_z(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
    z_rd = rd; z_wr = wr; z_addr = a; z_wdata = d;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!z_ready && lat < LIMIT);
    z_rd = 1'b0; z_wr = 1'b0;
    step();
  endtask

  initial begin
    int lat;
    int pulses;
    logic exp_drop_err;

    a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    z_rd = 0; z_wr = 0; z_addr = '0; z_wdata = '0;

    // ---- Reset: held low for two cycles ----
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_ready", a_ready, 32'h0);
    check("rst_busy",  a_busy,  32'h0);
    check("rst_err",   a_err,   32'h0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_ready || z_ready) pulses++;
    end
    check("idle_no_ready", pulses, 32'd0);

    // ---- Write then read, WAIT_CYCLES=3 ----
    access_a(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, lat);
    check("wr10_latency", lat, 32'd4);
    check("wr10_ready_gone", a_ready, 32'h0);
    check("wr10_rdata_untouched", a_rdata, 32'h0);
    access_a(1'b1, 1'b0, 8'h10, 32'h0, lat);
    check("rd10_latency", lat, 32'd4);
    check("rd10_rdata", a_rdata, 32'hDEAD_BEEF);
    check("rd10_err", a_err, 32'h0);

    // ---- WAIT_CYCLES=0: preload, then back-to-back reads ----
    access_z(1'b0, 1'b1, 8'h00, 32'h1, lat);
    check("z_wr00_latency", lat, 32'd1);
    access_z(1'b0, 1'b1, 8'h01, 32'h2, lat);
    check("z_wr01_latency", lat, 32'd1);
    z_rd = 1'b1; z_addr = 8'h00;
    step();
    check("z_b2b_ready0", z_ready, 32'h1);
    check("z_b2b_rdata0", z_rdata, 32'h1);
    z_addr = 8'h01;
    step();
    check("z_b2b_gap", z_ready, 32'h0);
    step();
    check("z_b2b_ready1", z_ready, 32'h1);
    check("z_b2b_rdata1", z_rdata, 32'h2);
    z_rd = 1'b0;
    step();
    check("z_b2b_idle", z_ready, 32'h0);
    check("z_err", z_err, 32'h0);

    // ---- Reset mid-write ----
    access_a(1'b0, 1'b1, 8'h30, 32'h1234_5678, lat);
    check("wr30_latency", lat, 32'd4);
    check("wr30_rdata_hold", a_rdata, 32'hDEAD_BEEF);
    a_wr = 1'b1; a_addr = 8'h30; a_wdata = 32'hFFFF_FFFF;
    step();  // accepted, counter=3
    step();  // BUSY, counter=2
    check("midwr_busy", a_busy, 32'h1);
    check("midwr_ready", a_ready, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", a_rdata, 32'h0);
    check("midrst_busy",  a_busy,  32'h0);
    check("midrst_ready", a_ready, 32'h0);
    a_wr = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    access_a(1'b1, 1'b0, 8'h30, 32'h0, lat);
    check("rd30_latency", lat, 32'd4);
    check("rd30_not_committed", a_rdata, 32'h1234_5678);

    // ---- Simultaneous read+write ----
    access_a(1'b1, 1'b1, 8'h20, 32'h5A5A_5A5A, lat);
    check("both_latency", lat, 32'd4);
    check("both_err", a_err, 32'h1);
    check("both_rdata_untouched", a_rdata, 32'h1234_5678);
    access_a(1'b1, 1'b0, 8'h20, 32'h0, lat);
    check("rd20_rdata", a_rdata, 32'h5A5A_5A5A);
    check("rd20_err_sticky", a_err, 32'h1);

    // ---- Request dropped one cycle into BUSY ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rst2_err", a_err, 32'h0);
    a_rd = 1'b1; a_addr = 8'h10;
    step();  // accepted
    step();  // one cycle into BUSY
    a_rd = 1'b0;
    lat = 2;
    while (!a_ready && lat < LIMIT) begin
      step();
      lat++;
    end
    check("drop_latency", lat, 32'd4);
    check("drop_rdata", a_rdata, 32'hDEAD_BEEF);
`ifdef MEM_REQ_CHECK_EN
    exp_drop_err = 1'b1;
`else
    exp_drop_err = 1'b0;
`endif
    check("drop_err", a_err, {31'h0, exp_drop_err});
    step();
    check("drop_idle_ready", a_ready, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_ready_unit
